// File: rtl/f_stage.sv
// -----------------------------------------------------------------------------
// f_stage
// Fetch stage of the five-stage MIPS pipeline. It holds the architectural
// fetch PC, drives the instruction-memory address and picks the next PC from
// the sequential, branch, jump, jump-register, ERET and exception-entry
// sources. It also flags fetch address errors and delay-slot membership. The
// F_* outputs feed the F/D pipeline register directly.
//
// Ports
//   clk          in   1  clock, rising edge
//   reset        in   1  synchronous, active-high; pc <= PC_RESET
//   en           in   1  PC update enable (0 = stall from the hazard unit)
//   Req          in   1  exception/interrupt request from CP0 -> PC_EXC
//   D_eret       in   1  instruction in D is ERET
//   EPC          in  32  ERET return address from CP0
//   D_is_bj      in   1  instruction in D is any branch or jump
//   D_br_taken   in   1  branch in D resolved taken
//   D_br_target  in  32  branch target
//   D_j          in   1  J/JAL in D
//   D_j_target   in  32  jump target
//   D_jr         in   1  JR/JALR in D
//   D_jr_target  in  32  forwarded rs value
//   i_addr       out 32  instruction memory address (= pc)
//   i_rdata      in  32  instruction word, combinational read of i_addr
//   F_instr      out 32  fetched instruction (0 when squashed or faulting)
//   F_pc         out 32  PC of the fetched instruction (always pc)
//   F_BD         out  1  fetched instruction sits in a delay slot
//   F_EXCcode    out  5  4 (AdEL) on a fetch address error, else 0
//
// Control semantics: there is no valid/ready handshake here. 'en' is a
// stall qualifier: when low the PC holds and any redirect presented by D is
// dropped (the hazard unit holds D and presents it again). 'Req' and 'reset'
// are not qualified by 'en'; reset beats Req, Req beats everything else.
// -----------------------------------------------------------------------------
module f_stage (
  input  logic        clk,
  input  logic        reset,
  input  logic        en,
  input  logic        Req,
  input  logic        D_eret,
  input  logic [31:0] EPC,
  input  logic        D_is_bj,
  input  logic        D_br_taken,
  input  logic [31:0] D_br_target,
  input  logic        D_j,
  input  logic [31:0] D_j_target,
  input  logic        D_jr,
  input  logic [31:0] D_jr_target,
  output logic [31:0] i_addr,
  input  logic [31:0] i_rdata,
  output logic [31:0] F_instr,
  output logic [31:0] F_pc,
  output logic        F_BD,
  output logic [4:0]  F_EXCcode
);

  localparam logic [31:0] PC_RESET = 32'h0000_3000;
  localparam logic [31:0] PC_EXC   = 32'h0000_4180;
  localparam logic [31:0] IM_LO    = 32'h0000_3000;
  localparam logic [31:0] IM_HI    = 32'h0000_6FFF;
  localparam logic [4:0]  EXC_ADEL = 5'd4;
  localparam logic [4:0]  EXC_NONE = 5'd0;

  logic [31:0] pc;
  logic [31:0] pc_next;
  logic        addr_err;

  // Next-PC select. Reset is handled in the register itself so it overrides
  // everything, including Req.
  always_comb begin
    pc_next = pc;
    if (Req)             pc_next = PC_EXC;
    else if (!en)        pc_next = pc;
    else if (D_eret)     pc_next = EPC;
    else if (D_jr)       pc_next = D_jr_target;
    else if (D_j)        pc_next = D_j_target;
    else if (D_br_taken) pc_next = D_br_target;
    else                 pc_next = pc + 32'd4;  // wraps modulo 2^32
  end

  always_ff @(posedge clk) begin
    if (reset) pc <= PC_RESET;
    else       pc <= pc_next;
  end

  // Misaligned or outside the instruction memory window.
  assign addr_err = (pc[1:0] != 2'b00) || (pc < IM_LO) || (pc > IM_HI);

  // ERET has no delay slot: whatever was fetched behind it is squashed to a
  // clean nop, and any address error on that discarded fetch is suppressed.
  always_comb begin
    F_instr   = i_rdata;
    F_EXCcode = EXC_NONE;
    if (D_eret) begin
      F_instr   = 32'd0;
      F_EXCcode = EXC_NONE;
    end else if (addr_err) begin
      F_instr   = 32'd0;
      F_EXCcode = EXC_ADEL;
    end
  end

  assign i_addr = pc;
  assign F_pc   = pc;
  assign F_BD   = D_is_bj & ~D_eret;

endmodule
